// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared encodings and constants for the full-speed USB transmitter
package usb_pkg;

    typedef enum logic [2:0] {
        PKT_NONE  = 3'd0,
        PKT_DATA0 = 3'd1,
        PKT_DATA1 = 3'd2,
        PKT_ACK   = 3'd3,
        PKT_NAK   = 3'd4,
        PKT_STALL = 3'd5
    } tx_packet_e;

    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;
    localparam logic [7:0] PID_STALL = 8'h1E;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] SYNC_BYTE = 8'h80;

    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_DATA,
        ST_CRC,
        ST_EOP_SE0,
        ST_EOP_J
    } tx_state_e;

    function automatic logic [7:0] pid_byte(input logic [2:0] code);
        case (code)
            PKT_DATA0: pid_byte = PID_DATA0;
            PKT_DATA1: pid_byte = PID_DATA1;
            PKT_ACK:   pid_byte = PID_ACK;
            PKT_NAK:   pid_byte = PID_NAK;
            PKT_STALL: pid_byte = PID_STALL;
            default:   pid_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/usb_tx_crc16.sv
// rtl/usb_tx_crc16.sv - serial CRC16 (x^16+x^15+x^2+1) over payload bits, MSB-aligned register
module usb_tx_crc16
    import usb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        enable,
    input  logic        bit_in,
    output logic [15:0] crc
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            crc <= CRC16_INIT;
        end else if (enable) begin
            crc <= {crc[14:0], 1'b0} ^ (((bit_in ^ crc[15]) == 1'b1) ? CRC16_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/usb_tx.sv
// rtl/usb_tx.sv - full-speed USB packet serializer: SYNC, PID, payload, CRC16, stuffing, NRZI, EOP
module usb_tx
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int MAX_BYTES    = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] tx_packet,
    input  logic [6:0] buffer_occupancy,
    input  logic [7:0] tx_packet_data,
    output logic       get_tx_packet_data,
    output logic       tx_transfer_active,
    output logic       dplus_out,
    output logic       dminus_out
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(MAX_BYTES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BYTE_MAX = BW'(MAX_BYTES);

    tx_state_e      state, state_next;
    logic [CW-1:0]  cnt;
    logic [3:0]     bit_idx;
    logic [2:0]     ones;
    logic [7:0]     pid_q, shreg, next_byte;
    logic [BW-1:0]  byte_cnt;
    logic [15:0]    crc;
    logic           stuffing, pending, is_data, fetched, nrzi;
    logic           bit_end, sending, raw_bit, need_stuff, advance, last_bit, line_level, req_valid;

    assign bit_end   = (cnt == CNT_LAST);
    assign sending   = state inside {ST_SYNC, ST_PID, ST_DATA, ST_CRC};
    assign req_valid = (tx_packet >= 3'd1) && (tx_packet <= 3'd5);

    // Raw (pre-NRZI) bit of the current bit period; a stuff period always carries 0
    always_comb begin
        raw_bit = 1'b1;
        case (state)
            ST_SYNC: raw_bit = SYNC_BYTE[bit_idx[2:0]];
            ST_PID:  raw_bit = pid_q[bit_idx[2:0]];
            ST_DATA: raw_bit = shreg[bit_idx[2:0]];
            ST_CRC:  raw_bit = ~crc[4'd15 - bit_idx];
            default: raw_bit = 1'b1;
        endcase
        if (stuffing) begin
            raw_bit = 1'b0;
        end
    end

    assign need_stuff = sending && !stuffing && raw_bit && (ones == 3'd5);
    assign advance    = bit_end && !need_stuff;
    assign last_bit   = (state == ST_CRC)     ? (bit_idx == 4'd15) :
                        (state == ST_EOP_SE0) ? (bit_idx == 4'd1)  :
                        (state == ST_EOP_J)   ? 1'b1 : (bit_idx == 4'd7);

    assign get_tx_packet_data = is_data && (state == ST_PID || state == ST_DATA) &&
                                (bit_idx == 4'd7) && (cnt == '0) && !stuffing &&
                                (buffer_occupancy != 7'd0) && (byte_cnt < BYTE_MAX);
    assign tx_transfer_active = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        line_level = raw_bit ? nrzi : ~nrzi;
        dplus_out  = 1'b1;
        dminus_out = 1'b0;
        case (state)
            ST_IDLE:    if (pending) state_next = ST_SYNC;
            ST_SYNC:    if (advance && last_bit) state_next = ST_PID;
            ST_PID:     if (advance && last_bit)
                            state_next = !is_data ? ST_EOP_SE0 : (fetched ? ST_DATA : ST_CRC);
            ST_DATA:    if (advance && last_bit) state_next = fetched ? ST_DATA : ST_CRC;
            ST_CRC:     if (advance && last_bit) state_next = ST_EOP_SE0;
            ST_EOP_SE0: if (advance && last_bit) state_next = ST_EOP_J;
            ST_EOP_J:   if (advance) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
        if (sending) begin
            dplus_out  = line_level;
            dminus_out = ~line_level;
        end else if (state == ST_EOP_SE0) begin
            dplus_out  = 1'b0;
            dminus_out = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            bit_idx   <= '0;
            ones      <= '0;
            stuffing  <= 1'b0;
            pending   <= 1'b0;
            is_data   <= 1'b0;
            fetched   <= 1'b0;
            nrzi      <= 1'b1;
            pid_q     <= '0;
            shreg     <= '0;
            next_byte <= '0;
            byte_cnt  <= '0;
        end else if (state == ST_IDLE) begin
            cnt      <= '0;
            bit_idx  <= '0;
            ones     <= '0;
            stuffing <= 1'b0;
            fetched  <= 1'b0;
            nrzi     <= 1'b1;
            byte_cnt <= '0;
            // Latch the request one cycle ahead of SYNC so the first bit starts on a clean period
            if (pending) begin
                pending <= 1'b0;
            end else if (req_valid) begin
                pending <= 1'b1;
                pid_q   <= pid_byte(tx_packet);
                is_data <= (tx_packet == PKT_DATA0) || (tx_packet == PKT_DATA1);
            end
        end else begin
            cnt <= bit_end ? '0 : cnt + 1'b1;
            if (get_tx_packet_data) begin
                fetched   <= 1'b1;
                next_byte <= tx_packet_data;
                byte_cnt  <= byte_cnt + 1'b1;
            end
            if (bit_end) begin
                nrzi <= line_level;
                if (sending) begin
                    ones     <= raw_bit ? ones + 3'd1 : 3'd0;
                    stuffing <= need_stuff;
                end
            end
            if (advance) begin
                if (state_next != state || (state == ST_DATA && last_bit)) begin
                    bit_idx <= '0;
                end else begin
                    bit_idx <= bit_idx + 4'd1;
                end
                if (state_next == ST_DATA && last_bit) begin
                    shreg   <= next_byte;
                    fetched <= 1'b0;
                end
            end
        end
    end

    usb_tx_crc16 u_crc (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == ST_IDLE),
        .enable (state == ST_DATA && bit_end && !stuffing),
        .bit_in (raw_bit),
        .crc    (crc)
    );

endmodule

// File: tb/tb_usb_tx.sv
// tb/tb_usb_tx.sv - scoreboard bench for usb_tx: expected line symbols queued, monitor compares
module tb_usb_tx;

    localparam int CPB  = 8;
    localparam int MAXB = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] tx_packet = 3'd0;
    logic [6:0] buffer_occupancy = 7'd0;
    logic [7:0] tx_packet_data = 8'd0;
    logic       get_tx_packet_data, tx_transfer_active, dplus_out, dminus_out;

    int errors = 0;
    int checks = 0;
    int strobe_total = 0;

    logic [1:0] exp_sym[$];
    int         exp_len[$];
    int         exp_strb[$];
    logic [7:0] buf_q[$];

    usb_tx #(.CLKS_PER_BIT(CPB), .MAX_BYTES(MAXB)) dut (
        .clk                (clk),
        .rst                (rst),
        .tx_packet          (tx_packet),
        .buffer_occupancy   (buffer_occupancy),
        .tx_packet_data     (tx_packet_data),
        .get_tx_packet_data (get_tx_packet_data),
        .tx_transfer_active (tx_transfer_active),
        .dplus_out          (dplus_out),
        .dminus_out         (dminus_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_buf();
        buffer_occupancy = (buf_q.size() > 127) ? 7'd127 : 7'(buf_q.size());
        tx_packet_data   = (buf_q.size() > 0) ? buf_q[0] : 8'd0;
    endtask

    // Expected wire image: raw bits, stuffing after six 1s, NRZI from J, then SE0 SE0 J
    task automatic expect_packet(input logic [7:0] pid, input logic [7:0] payload[$], input bit is_data);
        bit          raw[$];
        logic [7:0]  sync_b;
        logic [15:0] crc_r;
        logic        line;
        int          ones;
        int          n;
        sync_b = 8'h80;
        for (int i = 0; i < 8; i++) raw.push_back(sync_b[i]);
        for (int i = 0; i < 8; i++) raw.push_back(pid[i]);
        if (is_data) begin
            crc_r = 16'hFFFF;
            foreach (payload[k]) begin
                for (int i = 0; i < 8; i++) raw.push_back(payload[k][i]);
                crc_r = crc_r ^ {8'h00, payload[k]};
                for (int i = 0; i < 8; i++)
                    crc_r = crc_r[0] ? ((crc_r >> 1) ^ 16'hA001) : (crc_r >> 1);
            end
            crc_r = ~crc_r;
            for (int i = 0; i < 16; i++) raw.push_back(crc_r[i]);
        end
        line = 1'b1;
        ones = 0;
        n    = 0;
        foreach (raw[i]) begin
            if (!raw[i]) line = ~line;
            exp_sym.push_back(line ? 2'b10 : 2'b01);
            n++;
            ones = raw[i] ? ones + 1 : 0;
            if (ones == 6) begin
                line = ~line;
                exp_sym.push_back(line ? 2'b10 : 2'b01);
                n++;
                ones = 0;
            end
        end
        exp_sym.push_back(2'b00);
        exp_sym.push_back(2'b00);
        exp_sym.push_back(2'b10);
        n += 3;
        exp_len.push_back(n * CPB);
        exp_strb.push_back(is_data ? payload.size() : 0);
    endtask

    task automatic send(input logic [2:0] code);
        @(posedge clk); #1;
        tx_packet = code;
        @(posedge clk); #1;
        check("active_latency_low", tx_transfer_active, 0);
        tx_packet = 3'd0;
        @(posedge clk); #1;
        check("active_after_latency", tx_transfer_active, 1);
    endtask

    task automatic wait_done(input string name);
        bit timed_out = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk);
            if (!tx_transfer_active) begin
                timed_out = 1'b0;
                break;
            end
        end
        check({name, "_timeout"}, timed_out, 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Buffer model: a strobe seen in a cycle consumes the head byte at the following edge
    initial begin
        forever begin
            @(negedge clk);
            if (get_tx_packet_data === 1'b1 && !rst) begin
                @(posedge clk); #1;
                if (buf_q.size() > 0) void'(buf_q.pop_front());
                strobe_total++;
                drive_buf();
            end
        end
    end

    // Monitor: pops one expected symbol per bit period and holds it for every cycle of that period
    initial begin
        bit         in_xfer = 1'b0;
        bit         have_cur = 1'b0;
        int         cyc = 0;
        int         nstrb = 0;
        logic       prev_strb = 1'b0;
        logic [1:0] cur = 2'b10;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_xfer   = 1'b0;
                prev_strb = 1'b0;
            end else if (tx_transfer_active) begin
                if (!in_xfer) begin
                    in_xfer = 1'b1;
                    cyc     = 0;
                    nstrb   = 0;
                end
                if (cyc % CPB == 0) begin
                    have_cur = (exp_sym.size() > 0);
                    if (have_cur) begin
                        cur = exp_sym.pop_front();
                    end else begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_bit_period: got line %0d with no expected symbol at %0t",
                                 {dplus_out, dminus_out}, $time);
                    end
                end
                if (have_cur) check("line_symbol", {dplus_out, dminus_out}, cur);
                if (get_tx_packet_data) begin
                    nstrb++;
                    check("strobe_back_to_back", prev_strb, 0);
                end
                prev_strb = get_tx_packet_data;
                cyc++;
            end else begin
                prev_strb = 1'b0;
                if (in_xfer) begin
                    in_xfer = 1'b0;
                    if (exp_len.size() > 0 && exp_strb.size() > 0) begin
                        check("active_cycles", cyc, exp_len.pop_front());
                        check("strobe_count", nstrb, exp_strb.pop_front());
                    end else begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_transfer: got %0d active cycles with none expected", cyc);
                    end
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got no finish expected finish before 5ms");
        $fatal(1);
    end

    initial begin
        logic [7:0] none[$];
        logic [7:0] pay[$];
        int         base;
        bit         timed_out;

        repeat (3) @(posedge clk);
        #1;
        check("reset_dplus", dplus_out, 1);
        check("reset_dminus", dminus_out, 0);
        check("reset_active", tx_transfer_active, 0);
        check("reset_strobe", get_tx_packet_data, 0);
        rst = 1'b0;

        // ACK handshake
        expect_packet(8'hD2, none, 1'b0);
        send(3'd3);
        check("ack_first_sync_is_k", {dplus_out, dminus_out}, 2'b01);
        wait_done("ack");

        // Zero-length DATA1
        buf_q.delete();
        drive_buf();
        expect_packet(8'h4B, none, 1'b1);
        send(3'd2);
        wait_done("data1_zlp");

        // DATA0 with a single 0xFF byte
        buf_q = {8'hFF};
        drive_buf();
        expect_packet(8'hC3, buf_q, 1'b1);
        send(3'd1);
        wait_done("data0_ff");
        check("data0_ff_buffer_left", buf_q.size(), 0);

        // DATA0 with 70 bytes queued, 64 may be sent
        buf_q.delete();
        pay.delete();
        for (int i = 0; i < 70; i++) buf_q.push_back(8'((i * 37 + 5) & 255));
        for (int i = 0; i < MAXB; i++) pay.push_back(buf_q[i]);
        drive_buf();
        expect_packet(8'hC3, pay, 1'b1);
        send(3'd1);
        wait_done("data0_max");
        check("data0_max_buffer_left", buf_q.size(), 6);
        buf_q.delete();
        drive_buf();

        // STALL with a NAK request held during the transfer
        expect_packet(8'h1E, none, 1'b0);
        send(3'd5);
        tx_packet = 3'd4;
        repeat (40) @(posedge clk);
        #1;
        tx_packet = 3'd0;
        wait_done("stall_nak");
        check("stall_nak_no_leftover", exp_sym.size(), 0);

        // Reset in the middle of a DATA0 payload
        pay.delete();
        for (int i = 0; i < 10; i++) pay.push_back(8'(8'hA0 + i));
        buf_q = pay;
        drive_buf();
        expect_packet(8'hC3, pay, 1'b1);
        base = strobe_total;
        send(3'd1);
        timed_out = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #2;
            if (strobe_total >= base + 3) begin
                timed_out = 1'b0;
                break;
            end
        end
        check("midreset_reach_data_timeout", timed_out, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midreset_dplus", dplus_out, 1);
        check("midreset_dminus", dminus_out, 0);
        check("midreset_active", tx_transfer_active, 0);
        check("midreset_strobe", get_tx_packet_data, 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_sym.delete();
        exp_len.delete();
        exp_strb.delete();
        buf_q.delete();
        drive_buf();

        // ACK after the aborted packet
        expect_packet(8'hD2, none, 1'b0);
        send(3'd3);
        wait_done("ack_after_reset");
        check("final_no_leftover_symbols", exp_sym.size(), 0);
        check("final_no_leftover_lengths", exp_len.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
